// File: rtl/minsec_btn_event_decoder.sv
// Minute/second-setting button decoder: turns three debounced button levels into
// registered short-press, long-press and auto-repeat pulses, one FSM per button.
module minsec_btn_event_decoder #(
  parameter int LONG_TICKS   = 1000,
  parameter int REPEAT_TICKS = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [2:0] btn_in,
  output logic [2:0] short_press,
  output logic [2:0] long_press,
  output logic [2:0] repeat_pulse,
  output logic       any_event
);

  localparam int MAX_TICKS = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int CW        = $clog2(MAX_TICKS);
  localparam logic [CW-1:0] LONG_LAST   = CW'(LONG_TICKS - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_TICKS - 1);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  state_t        state_q [3];
  state_t        state_d [3];
  logic [CW-1:0] cnt_q   [3];
  logic [CW-1:0] cnt_d   [3];
  logic [2:0]    btn_q;
  logic [2:0]    short_d, long_d, rep_d;
  logic [2:0]    short_ev, long_ev, rep_ev;

  // NOTE: every output of this block is given a default before the case
  // statement, so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    short_d = '0;
    long_d  = '0;
    rep_d   = '0;
    for (int i = 0; i < 3; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        IDLE: begin
          if (btn_q[i]) begin
            state_d[i] = PRESSED;
            cnt_d[i]   = '0;
          end
        end
        PRESSED: begin
          // Release is tested first so it wins over a coinciding threshold tick.
          if (!btn_q[i]) begin
            short_d[i] = 1'b1;
            state_d[i] = IDLE;
          end else if (tick) begin
            if (cnt_q[i] == LONG_LAST) begin
              long_d[i]  = 1'b1;
              cnt_d[i]   = '0;
              state_d[i] = HELD;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
        HELD: begin
          if (!btn_q[i]) begin
            state_d[i] = IDLE;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == REPEAT_LAST) begin
              rep_d[i] = 1'b1;
              cnt_d[i] = '0;
            end else begin
              cnt_d[i] = cnt_q[i] + 1'b1;
            end
          end
        end
        default: begin
          state_d[i] = IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_q        <= '0;
      // NOTE: the small counter arrays are explicitly reset so a hold in progress
      // is discarded and timing restarts from zero after reset.
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= IDLE;
        cnt_q[i]   <= '0;
      end
      short_ev     <= '0;
      long_ev      <= '0;
      rep_ev       <= '0;
      short_press  <= '0;
      long_press   <= '0;
      repeat_pulse <= '0;
      any_event    <= 1'b0;
    end else begin
      btn_q <= btn_in;
      for (int i = 0; i < 3; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      short_ev     <= short_d;
      long_ev      <= long_d;
      rep_ev       <= rep_d;
      // Output stage: pulses land two edges after btn_in is first sampled.
      short_press  <= short_ev;
      long_press   <= long_ev;
      repeat_pulse <= rep_ev;
      any_event    <= |{short_ev, long_ev, rep_ev};
    end
  end

endmodule
